// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-stage controller and its
// Memory-Writeback pipeline register.
//   state_t    : controller state (IDLE, WAIT)
//   wb_sel_t   : write-back data source (SEL_ALU, SEL_MEM, SEL_LINK)
//   wb_entry_t : one Memory-Writeback register entry
//   wb_select  : priority encoder for the write-back data source
package mem_stage_pkg;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2
    } wb_sel_t;

    typedef struct packed {
        logic        valid;
        logic        reg_wr;
        logic [4:0]  rd;
        logic [31:0] wr_data;
        logic        err;
    } wb_entry_t;

    // The link value wins over loaded data, which wins over the ALU result.
    function automatic wb_sel_t wb_select(input logic use_link, input logic mem_to_reg);
        wb_sel_t sel;
        if (use_link) begin
            sel = SEL_LINK;
        end else if (mem_to_reg) begin
            sel = SEL_MEM;
        end else begin
            sel = SEL_ALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg
// Memory-Writeback pipeline register.
//   clk        : clock
//   reset      : synchronous active-high reset, clears the entry
//   bubble     : load an all-zero entry this cycle instead of load_entry
//   load_entry : entry to capture when not bubbling
//   entry      : registered entry seen by the write-back stage
module mem_wb_pipe_reg
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      bubble,
    input  wb_entry_t load_entry,
    output wb_entry_t entry
);

    // The register reloads every cycle; a bubble is simply an all-zero entry,
    // so downstream never sees stale fields behind a cleared valid bit.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            entry <= '0;
        end else begin
            entry <= load_entry;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller. Issues data-memory requests for loads/stores held
// in the Execute-Memory register, stalls the upstream pipe while a request is
// outstanding, aborts on timeout or misalignment, and fills the
// Memory-Writeback register.
//   clk, reset            : clock, synchronous active-high reset
//   *_mem_i               : Execute-Memory register fields
//   dmem_req/wr/addr/wdata: request side of the data-memory handshake
//   dmem_ack_i/rdata_i    : completion and load data (ack may be same cycle)
//   stall_o               : hold the upstream pipe registers
//   *_wb_o                : Memory-Writeback register fields
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_mem_i,
    input  logic        reg_wr_mem_i,
    input  logic        mem_to_reg_mem_i,
    input  logic        mem_wr_mem_i,
    input  logic [4:0]  rd_mem_i,
    input  logic [31:0] res_alu_mem_i,
    input  logic [31:0] r_data_p2_mem_i,
    input  logic [31:0] next_seq_pc_mem_i,
    input  logic        use_link_reg_mem_i,
    output logic        dmem_req_o,
    output logic        dmem_wr_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        valid_wb_o,
    output logic        reg_wr_wb_o,
    output logic [4:0]  rd_wb_o,
    output logic [31:0] wr_data_wb_o,
    output logic        err_wb_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             access;
    logic             misaligned;
    logic             timeout_hit;
    logic             complete;
    logic             abort;
    logic             err_entry;
    logic             result_entry;
    logic             bubble;
    wb_sel_t          wb_sel;
    logic [31:0]      wb_data;
    wb_entry_t        load_entry;
    wb_entry_t        wb_entry;

    assign access      = valid_mem_i & (mem_to_reg_mem_i | mem_wr_mem_i);
    assign misaligned  = res_alu_mem_i[1:0] != 2'b00;
    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_LAST);

    // Requests are driven straight from the MEM inputs, which the stall keeps
    // stable, so a slave can ack in the very cycle the request appears.
    assign dmem_req_o   = access & ~misaligned & ((state == IDLE) | (state == WAIT));
    assign dmem_wr_o    = mem_wr_mem_i;
    assign dmem_addr_o  = res_alu_mem_i;
    assign dmem_wdata_o = r_data_p2_mem_i;

    // An ack only means something while we are requesting; an abort is the
    // last waiting cycle without an ack, and it releases the stall at once.
    assign complete = dmem_req_o & dmem_ack_i;
    assign abort    = timeout_hit & ~dmem_ack_i;

    assign stall_o = ((state == IDLE) & access & ~misaligned & ~dmem_ack_i)
                   | ((state == WAIT) & ~dmem_ack_i & ~timeout_hit);

    assign err_entry    = ((state == IDLE) & access & misaligned) | abort;
    assign result_entry = ((state == IDLE) & valid_mem_i & ~access) | complete;
    assign bubble       = ~(err_entry | result_entry);

    assign wb_sel = wb_select(use_link_reg_mem_i, mem_to_reg_mem_i);

    // Write-back data source; the link address takes precedence so a
    // jump-and-link never picks up memory or ALU data.
    always_comb begin
        wb_data = res_alu_mem_i;
        case (wb_sel)
            SEL_LINK: wb_data = next_seq_pc_mem_i;
            SEL_MEM:  wb_data = dmem_rdata_i;
            default:  wb_data = res_alu_mem_i;
        endcase
    end

    // Build the entry for the Memory-Writeback register. Error entries are
    // valid but never write the register file; they carry the faulting
    // address as data to help whoever handles the error.
    always_comb begin
        load_entry = '0;
        if (err_entry) begin
            load_entry.valid   = 1'b1;
            load_entry.reg_wr  = 1'b0;
            load_entry.rd      = rd_mem_i;
            load_entry.wr_data = res_alu_mem_i;
            load_entry.err     = 1'b1;
        end else if (result_entry) begin
            load_entry.valid   = 1'b1;
            load_entry.reg_wr  = reg_wr_mem_i;
            load_entry.rd      = rd_mem_i;
            load_entry.wr_data = wb_data;
            load_entry.err     = 1'b0;
        end
    end

    // Controller FSM and wait counter. The counter reads 1 in the first
    // WAIT cycle, so the IDLE cycle that issued the request counts as the
    // first of the TIMEOUT_CYCLES allowed cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !misaligned && !dmem_ack_i) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i || timeout_hit) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    mem_wb_pipe_reg u_mem_wb (
        .clk        (clk),
        .reset      (reset),
        .bubble     (bubble),
        .load_entry (load_entry),
        .entry      (wb_entry)
    );

    assign valid_wb_o   = wb_entry.valid;
    assign reg_wr_wb_o  = wb_entry.reg_wr;
    assign rd_wb_o      = wb_entry.rd;
    assign wr_data_wb_o = wb_entry.wr_data;
    assign err_wb_o     = wb_entry.err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl with a short timeout. Each
// instruction is described as a transaction (fields plus ack delay); the
// model derives from the transaction alone how many cycles it occupies the
// stage, when the pipe stalls and what lands in the write-back register.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic        valid;
        logic        reg_wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } wb_exp_t;

    typedef struct {
        logic        valid;
        logic        reg_wr;
        logic        ld;
        logic        st;
        logic        use_link;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] link;
        logic [31:0] rdata;
        int          ack_delay;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_mem_i, reg_wr_mem_i, mem_to_reg_mem_i, mem_wr_mem_i;
    logic [4:0]  rd_mem_i;
    logic [31:0] res_alu_mem_i, r_data_p2_mem_i, next_seq_pc_mem_i;
    logic        use_link_reg_mem_i;
    logic        dmem_req_o, dmem_wr_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, valid_wb_o, reg_wr_wb_o, err_wb_o;
    logic [4:0]  rd_wb_o;
    logic [31:0] wr_data_wb_o;

    int      vectors     = 0;
    int      miscompares = 0;
    int      stall_seen  = 0;
    int      stall_mark;
    logic    check_en    = 1'b0;
    logic    exp_req, exp_stall, exp_wr;
    logic [31:0] exp_addr, exp_wdata;
    wb_exp_t exp_wb;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .valid_mem_i        (valid_mem_i),
        .reg_wr_mem_i       (reg_wr_mem_i),
        .mem_to_reg_mem_i   (mem_to_reg_mem_i),
        .mem_wr_mem_i       (mem_wr_mem_i),
        .rd_mem_i           (rd_mem_i),
        .res_alu_mem_i      (res_alu_mem_i),
        .r_data_p2_mem_i    (r_data_p2_mem_i),
        .next_seq_pc_mem_i  (next_seq_pc_mem_i),
        .use_link_reg_mem_i (use_link_reg_mem_i),
        .dmem_req_o         (dmem_req_o),
        .dmem_wr_o          (dmem_wr_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_ack_i         (dmem_ack_i),
        .dmem_rdata_i       (dmem_rdata_i),
        .stall_o            (stall_o),
        .valid_wb_o         (valid_wb_o),
        .reg_wr_wb_o        (reg_wr_wb_o),
        .rd_wb_o            (rd_wb_o),
        .wr_data_wb_o       (wr_data_wb_o),
        .err_wb_o           (err_wb_o)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every output against the model's expectation for this cycle.
    task automatic checkOutput();
        check32("dmem_req", 32'(dmem_req_o), 32'(exp_req));
        check32("stall", 32'(stall_o), 32'(exp_stall));
        if (exp_req) begin
            check32("dmem_wr", 32'(dmem_wr_o), 32'(exp_wr));
            check32("dmem_addr", dmem_addr_o, exp_addr);
            check32("dmem_wdata", dmem_wdata_o, exp_wdata);
        end
        check32("valid_wb", 32'(valid_wb_o), 32'(exp_wb.valid));
        check32("reg_wr_wb", 32'(reg_wr_wb_o), 32'(exp_wb.reg_wr));
        check32("err_wb", 32'(err_wb_o), 32'(exp_wb.err));
        if (!exp_wb.valid || !exp_wb.err) begin
            check32("rd_wb", 32'(rd_wb_o), 32'(exp_wb.rd));
            check32("wr_data_wb", wr_data_wb_o, exp_wb.data);
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput();
            if (stall_o) stall_seen++;
        end
    end

    // One clock of stimulus: the entry expected in the WB register after
    // this edge becomes the expectation for the next cycle.
    task automatic driveCycle(input logic rst, input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic e_stall, input wb_exp_t e_next);
        reset        = rst;
        dmem_ack_i   = ack;
        dmem_rdata_i = rdata;
        exp_req      = e_req;
        exp_stall    = e_stall;
        @(posedge clk);
        #1;
        exp_wb = e_next;
    endtask

    function automatic txn_t mk(input logic valid, input logic reg_wr, input logic ld,
                                input logic st, input logic use_link, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [31:0] link, input logic [31:0] rdata,
                                input int ack_delay);
        txn_t t;
        t.valid = valid; t.reg_wr = reg_wr; t.ld = ld; t.st = st; t.use_link = use_link;
        t.rd = rd; t.alu = alu; t.wdata = wdata; t.link = link; t.rdata = rdata;
        t.ack_delay = ack_delay;
        return t;
    endfunction

    task automatic setInputs(input txn_t t);
        valid_mem_i        = t.valid;
        reg_wr_mem_i       = t.reg_wr;
        mem_to_reg_mem_i   = t.ld;
        mem_wr_mem_i       = t.st;
        use_link_reg_mem_i = t.use_link;
        rd_mem_i           = t.rd;
        res_alu_mem_i      = t.alu;
        r_data_p2_mem_i    = t.wdata;
        next_seq_pc_mem_i  = t.link;
        exp_wr             = t.st;
        exp_addr           = t.alu;
        exp_wdata          = t.wdata;
    endtask

    // Transaction-level model: an instruction occupies one cycle unless it
    // is an aligned access, which lasts until its ack or TO cycles total.
    task automatic applyStimulus(input txn_t t);
        logic    acc, mis, req;
        int      n;
        wb_exp_t res;
        acc = t.valid && (t.ld || t.st);
        mis = t.alu[1:0] != 2'b00;
        req = acc && !mis;
        res = '0;
        n   = 1;
        if (!t.valid) begin
            res = '0;
        end else if (acc && mis) begin
            res.valid = 1'b1; res.err = 1'b1;
        end else if (acc && !(t.ack_delay >= 0 && t.ack_delay < TO)) begin
            n = TO;
            res.valid = 1'b1; res.err = 1'b1;
        end else begin
            if (acc) n = t.ack_delay + 1;
            res.valid  = 1'b1;
            res.reg_wr = t.reg_wr;
            res.rd     = t.rd;
            res.data   = t.use_link ? t.link : (t.ld ? t.rdata : t.alu);
        end
        setInputs(t);
        for (int k = 0; k < n; k++) begin
            driveCycle(1'b0, k == t.ack_delay, (k == t.ack_delay) ? t.rdata : 32'hBAD0_0BAD,
                       req, k < n - 1, (k == n - 1) ? res : wb_exp_t'('0));
        end
    endtask

    txn_t nop;

    initial begin
        nop = mk(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, -1);
        setInputs(nop);
        reset = 1'b1; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        exp_req = 1'b0; exp_stall = 1'b0;
        @(posedge clk);
        #1;
        exp_wb   = '0;
        check_en = 1'b1;
        driveCycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        check32("reset_valid_wb", 32'(valid_wb_o), 32'd0);

        // Stray ack with nothing outstanding is ignored.
        applyStimulus(mk(0, 0, 0, 0, 0, 5'd3, 32'h10, 32'h0, 32'h0, 32'h1111, 0));

        // ALU op.
        stall_mark = stall_seen;
        applyStimulus(mk(1, 1, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0));
        check32("alu_data_lit", wr_data_wb_o, 32'h0000_1234);
        check32("alu_rd_lit", 32'(rd_wb_o), 32'd5);
        check32("alu_stall_lit", 32'(stall_seen - stall_mark), 32'd0);

        // Zero-wait load.
        applyStimulus(mk(1, 1, 1, 0, 0, 5'd7, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 0));
        check32("ld0_data_lit", wr_data_wb_o, 32'hDEAD_BEEF);

        // 3-cycle store, then a back-to-back load with one wait.
        stall_mark = stall_seen;
        applyStimulus(mk(1, 0, 0, 1, 0, 5'd9, 32'h40, 32'hCAFE_F00D, 32'h0, 32'h0, 2));
        check32("st_stall_lit", 32'(stall_seen - stall_mark), 32'd2);
        check32("st_regwr_lit", 32'(reg_wr_wb_o), 32'd0);
        applyStimulus(mk(1, 1, 1, 0, 0, 5'd12, 32'h44, 32'h0, 32'h0, 32'h0BAD_CAFE, 1));

        // Timeout with ack never arriving, followed by an idle slot.
        stall_mark = stall_seen;
        applyStimulus(mk(1, 1, 1, 0, 0, 5'd13, 32'h80, 32'h0, 32'h0, 32'h0, -1));
        check32("to_stall_lit", 32'(stall_seen - stall_mark), 32'd3);
        check32("to_err_lit", 32'(err_wb_o), 32'd1);
        applyStimulus(nop);

        // Ack in the final allowed cycle still completes.
        applyStimulus(mk(1, 1, 1, 0, 0, 5'd14, 32'h88, 32'h0, 32'h0, 32'h5555_AAAA, TO - 1));

        // Misaligned load (ack ignored) and misaligned store.
        applyStimulus(mk(1, 1, 1, 0, 0, 5'd15, 32'h102, 32'h0, 32'h0, 32'h1, 0));
        check32("mis_err_lit", 32'(err_wb_o), 32'd1);
        applyStimulus(mk(1, 0, 0, 1, 0, 5'd0, 32'h41, 32'h77, 32'h0, 32'h0, 0));

        // Jump-and-link, then link taking priority over load data.
        applyStimulus(mk(1, 1, 0, 0, 1, 5'd31, 32'h3000, 32'h0, 32'h2008, 32'h0, -1));
        check32("jal_data_lit", wr_data_wb_o, 32'h0000_2008);
        applyStimulus(mk(1, 1, 1, 0, 1, 5'd1, 32'h200, 32'h0, 32'h400C, 32'h9999, 1));

        // Reset while waiting: outputs follow the MEM inputs during the reset
        // cycle; afterwards everything is quiet and a late ack is ignored.
        setInputs(mk(1, 1, 1, 0, 0, 5'd6, 32'h300, 32'h0, 32'h0, 32'h0, -1));
        driveCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, '0);
        driveCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, '0);
        driveCycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, '0);
        setInputs(nop);
        driveCycle(1'b0, 1'b1, 32'h7777, 1'b0, 1'b0, '0);
        check32("rst_wait_valid_lit", 32'(valid_wb_o), 32'd0);
        applyStimulus(mk(1, 1, 1, 0, 0, 5'd8, 32'h304, 32'h0, 32'h0, 32'h1357_9BDF, 0));

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
